// File: rtl/toggle_period_meter_pkg.sv
// Shared timing constants and state encoding for the toggle period meter
// and its blink-generator counterpart, so both ends agree on the half-period.
package toggle_period_meter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_STALLED = 2'd2;

    localparam int CLK_HZ           = 27_000_000;
    localparam int DEF_EXPECT_HALF  = CLK_HZ / 2;
    localparam int DEF_TOL          = DEF_EXPECT_HALF / 10;
    localparam int DEF_TIMEOUT      = CLK_HZ;

endpackage

// File: rtl/toggle_period_meter_edge_sync.sv
// Multi-flop synchronizer with a history flop; flags both rising and falling
// edges of an asynchronous input. Reusable for buttons and similar inputs.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hist_r;

    // Shift the async input through the synchronizer chain and keep one cycle of history
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            hist_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], i_async};
            hist_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign o_level = sync_r[SYNC_STAGES-1];
    assign o_edge  = sync_r[SYNC_STAGES-1] ^ hist_r;

endmodule

// File: rtl/toggle_period_meter.sv
// Measures edge-to-edge interval of a slow toggling input, flags lock against
// an expected half-period and declares a stall when no edge arrives in time.
module toggle_period_meter
    import toggle_period_meter_pkg::*;
#(
    parameter int CNT_W          = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int EXPECT_HALF    = DEF_EXPECT_HALF,
    parameter int TOL            = DEF_TOL,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sig,
    output logic [CNT_W-1:0] o_half_period,
    output logic             o_valid,
    output logic             o_locked,
    output logic             o_timeout,
    output logic             o_level
);

    localparam logic [CNT_W-1:0] EXP_C = CNT_W'(EXPECT_HALF);
    localparam logic [CNT_W-1:0] TOL_C = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    function automatic logic within_tol(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] diff;
        diff = (val >= EXP_C) ? (val - EXP_C) : (EXP_C - val);
        return (diff <= TOL_C);
    endfunction

    logic             sync_level_s;
    logic             edge_s;
    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_sig),
        .o_level (sync_level_s),
        .o_edge  (edge_s)
    );

    // Interval counter: restarts at 1 on each edge, saturates at the timeout so it never wraps
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (edge_s) begin
            cnt_r <= ONE_C;
        end else if (cnt_r != TMO_C) begin
            cnt_r <= cnt_r + ONE_C;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Measurement state machine and registered outputs; an edge always wins over the timeout
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r       <= ST_IDLE;
            o_half_period <= {CNT_W{1'b0}};
            o_valid       <= 1'b0;
            o_locked      <= 1'b0;
            o_timeout     <= 1'b0;
            o_level       <= 1'b0;
        end else begin
            o_level <= sync_level_s;
            o_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (edge_s) begin
                        state_r <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (edge_s) begin
                        o_half_period <= cnt_r;
                        o_valid       <= 1'b1;
                        o_locked      <= within_tol(cnt_r);
                    end else if (cnt_r == TMO_C) begin
                        state_r   <= ST_STALLED;
                        o_timeout <= 1'b1;
                        o_locked  <= 1'b0;
                    end
                end
                ST_STALLED: begin
                    if (edge_s) begin
                        state_r   <= ST_MEASURE;
                        o_timeout <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    o_locked  <= 1'b0;
                    o_timeout <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/toggle_period_meter.md
Name: toggle_period_meter

Overview:
- Receive-side counterpart to the LED blink generator: watches a slowly toggling input (blink line, heartbeat, external square wave) and measures it.
- Reports the time between successive edges in i_clk cycles and flags whether the measurement is within tolerance of an expected half-period.
- Detects a stalled input with a timeout.
- Sits at board level next to the blinker; used for self-test loopback and heartbeat supervision.

Parameters:
- CNT_W, 32, width of the cycle counter and of o_half_period.
- SYNC_STAGES, 2, synchronizer flop count for i_sig (minimum 2).
- EXPECT_HALF, 13500000, expected cycles between edges (0.5 s at 27 MHz).
- TOL, 1350000, allowed absolute deviation from EXPECT_HALF for lock.
- TIMEOUT_CYCLES, 27000000, cycles without an edge before a stall is declared. Must satisfy EXPECT_HALF+TOL < TIMEOUT_CYCLES < 2^CNT_W.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- i_sig  input  1  asynchronous toggling input under measurement.
- o_half_period  output  CNT_W  last measured edge-to-edge interval in cycles; holds until the next report.
- o_valid  output  1  one-cycle strobe when o_half_period is updated.
- o_locked  output  1  last report satisfied |o_half_period − EXPECT_HALF| ≤ TOL.
- o_timeout  output  1  stall flag; held high until the next detected edge.
- o_level  output  1  synchronized level of i_sig.

Behaviour:
- Reset (async assert, sync release): all outputs 0, synchronizer flops 0, counter 0, state IDLE.
  - If i_sig is high at release, the resulting detected rising edge is treated as an ordinary first edge.
- Synchronizer: SYNC_STAGES flops, then one history flop.
  - edge = synced XOR history, covering both rising and falling edges.
  - o_level = synced value.
  - Edge detect occurs SYNC_STAGES+1 cycles after the i_sig transition.
- Counter:
  - Cleared to 1 on the cycle edge is high.
  - Otherwise increments, saturating at TIMEOUT_CYCLES.
  - Reported value equals t1 − t0, where t0 and t1 are consecutive edge-detect cycles.
- States:
  - IDLE: waiting for the first edge. On edge → MEASURE, no report.
  - MEASURE, on edge:
    - o_half_period ← counter; o_valid = 1 on the next cycle (registered, 1-cycle latency from edge detect).
    - o_locked updated from that value.
    - Stay in MEASURE.
  - MEASURE, no edge and counter == TIMEOUT_CYCLES:
    - → STALLED; o_timeout ← 1, o_locked ← 0.
    - o_half_period holds its old value; no o_valid.
  - STALLED, on edge:
    - → MEASURE; o_timeout ← 0; counter restarts.
    - No report; this edge is the new reference.
- Simultaneous edge and counter == TIMEOUT_CYCLES: the edge wins. Report TIMEOUT_CYCLES, no timeout, o_locked computed normally (0).
- Lock comparison uses unsigned magnitude of the difference. No wrap: the counter never exceeds TIMEOUT_CYCLES.
- o_valid never asserts on two consecutive cycles; edges are at least SYNC_STAGES apart in practice.
- Reset mid-measurement: immediate clear of all state and outputs; the next edge is treated as a first edge.

Decomposition:
- Shared package: state encoding localparams (IDLE, MEASURE, STALLED) and default timing constants (27 MHz clock, 0.5 s half-period).
  - Shared with the blinker so both ends agree on EXPECT_HALF.
- One sub-module, edge_sync:
  - Parameter SYNC_STAGES.
  - Ports i_clk, i_rst_n, i_async, o_level, o_edge.
  - Reusable for buttons and other async inputs.

Test Plan (sim parameters: SYNC_STAGES=2, EXPECT_HALF=20, TOL=2, TIMEOUT_CYCLES=100, CNT_W=8):
1. Assert i_rst_n=0 with i_sig=1 → all outputs 0 during reset. After release, o_level goes to 1 three cycles later, with no o_valid.
2. Toggle i_sig every 20 cycles for 6 edges:
   - first edge → no o_valid;
   - each later edge → o_valid pulse 1 cycle after edge detect, o_half_period=20, o_locked=1.
3. Intervals of 22, then 23 cycles → reports 22 with o_locked=1, then 23 with o_locked=0.
4. Hold i_sig 150 cycles after an edge:
   - o_timeout rises exactly when the counter reaches 100, o_locked=0, o_half_period unchanged;
   - next edge clears o_timeout with no o_valid;
   - the following edge 20 cycles later reports 20.
5. Edge detected exactly when the counter reaches 100 → o_valid with o_half_period=100, o_timeout stays 0, o_locked=0.
6. Pulse i_rst_n low for 1 cycle mid-interval (counter ≈10) → outputs clear asynchronously. First edge after release gives no report; the second reports its true interval.
